// File: rtl/spi_keys_frame_tx.sv
// Debounced key-vector snapshot shipped as a framed SPI-master transfer:
// HEADER byte, key bits MSB first, then even parity over the keys.
module spi_keys_frame_tx #(
  parameter int unsigned NUM_KEYS        = 61,
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REFRESH_CYCLES  = 0,
  parameter bit          CPOL            = 1'b0,
  parameter logic [7:0]  HEADER          = 8'hA5,
  parameter int unsigned GAP_CYCLES      = 8
) (
  input  logic                clk_g_i,
  input  logic                rst_g_i,
  input  logic [NUM_KEYS-1:0] keys_i_g,
  output logic                spi_clk_g_o,
  output logic                spi_mosi_g_o,
  output logic                spi_cs_n_g_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int unsigned FRAME_LEN = NUM_KEYS + 9;
  localparam int unsigned BIT_W     = $clog2(NUM_KEYS + 10);
  localparam int unsigned DIV_W     = $clog2(CLK_DIV + 1);
  localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam int unsigned REF_W     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
  logic                   sck_q, sck_d;
  logic                   cs_n_q, cs_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [NUM_KEYS-1:0]    sync1_q, sync2_q, prev_q, stable_q;
  logic [DEB_W-1:0]       deb_cnt_q;
  logic                   pending_q;
  logic                   start_c;
  logic                   accept_c;
  logic                   refresh_hit_c;
  logic [FRAME_LEN-1:0]   frame_c;

  assign frame_c  = {HEADER, stable_q, ^stable_q};
  assign accept_c = (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES)) && (sync2_q == prev_q)
                    && (sync2_q != stable_q);

  // Synchroniser, whole-vector debounce and the pending-frame flag
  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      deb_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      sync1_q <= keys_i_g;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q != DEB_W'(DEBOUNCE_CYCLES)) begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
      if (accept_c) begin
        stable_q <= sync2_q;
      end
      // A request arriving on the start cycle survives and yields one follow-up frame
      pending_q <= (pending_q & ~start_c) | accept_c | refresh_hit_c;
    end
  end

  if (REFRESH_CYCLES > 0) begin : g_refresh
    logic [REF_W-1:0] ref_cnt_q;

    assign refresh_hit_c = (state_q == ST_IDLE) && (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk_g_i) begin
      if (rst_g_i || start_c || refresh_hit_c) begin
        ref_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
        ref_cnt_q <= ref_cnt_q + REF_W'(1);
      end
    end
  end else begin : g_no_refresh
    assign refresh_hit_c = 1'b0;
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      sck_q   <= CPOL;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; MOSI is the top of the shift register
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          start_c = 1'b1;
          shreg_d = frame_c;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          sck_d = ~sck_q;
          // Trailing edge: present the next bit, zero-filling behind the last one
          if (sck_q != CPOL) begin
            shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b0};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(FRAME_LEN - 1)) begin
              state_d = ST_TRAIL;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_TRAIL: begin
        sck_d = CPOL;
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          shreg_d = '0;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign spi_clk_g_o  = sck_q;
  assign spi_mosi_g_o = shreg_q[FRAME_LEN-1];
  assign spi_cs_n_g_o = cs_n_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule
